// File: rtl/sodor_arb_pkg.sv
// Shared types and widths for the Sodor data-memory arbiter.
package sodor_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned MEM_TYP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
        logic                   wen;
        logic [MEM_TYP_W-1:0]   typ;
    } req_t;

endpackage

// File: rtl/sodor_dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter.
// slave = arbiter view, master = surrounding harness (requesters + memory model).
interface sodor_dmem_arbiter_if #(
    parameter int unsigned ADDR_W = sodor_arb_pkg::DMEM_ADDR_W,
    parameter int unsigned DATA_W = sodor_arb_pkg::DMEM_DATA_W
);
    import sodor_arb_pkg::*;

    logic [1:0]             rq_valid;
    logic [1:0]             rq_ready;
    logic [2*ADDR_W-1:0]    rq_addr;
    logic [2*DATA_W-1:0]    rq_data;
    logic [1:0]             rq_wen;
    logic [2*MEM_TYP_W-1:0] rq_typ;

    logic [1:0]             rs_valid;
    logic [DATA_W-1:0]      rs_data;
    logic                   rs_err;

    logic                   mem_req_valid;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic [DATA_W-1:0]      mem_req_data;
    logic                   mem_req_write_en;
    logic [MEM_TYP_W-1:0]   mem_req_typ;
    logic                   mem_resp_valid;
    logic [DATA_W-1:0]      mem_resp_data;

    modport slave (
        input  rq_valid, rq_addr, rq_data, rq_wen, rq_typ,
        output rq_ready, rs_valid, rs_data, rs_err,
        output mem_req_valid, mem_req_addr, mem_req_data, mem_req_write_en, mem_req_typ,
        input  mem_resp_valid, mem_resp_data
    );

    modport master (
        output rq_valid, rq_addr, rq_data, rq_wen, rq_typ,
        input  rq_ready, rs_valid, rs_data, rs_err,
        input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_write_en, mem_req_typ,
        output mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/sodor_dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to prio.
module sodor_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant_c
);

    assign grant_c[0] = valid[0] & (~valid[1] | ~prio);
    assign grant_c[1] = valid[1] & (~valid[0] |  prio);

endmodule

// File: rtl/sodor_dmem_arbiter.sv
// Serialises two requesters onto the single Sodor data-memory port,
// one transaction at a time, with a read timeout that returns an error.
module sodor_dmem_arbiter
    import sodor_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    sodor_dmem_arbiter_if.slave bus,
    output logic                busy,
    output logic                grant_id
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    req_t              req_q;
    logic              prio;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        rs_valid;
    logic [DATA_W-1:0] rs_data;
    logic              rs_err;
    logic              mem_req_valid;
    logic              mem_req_write_en;

    logic [1:0]        pick_c;
    logic [1:0]        ready_c;
    logic              accept_c;
    logic              gidx_c;
    req_t              sel_c;

    sodor_rr_arb2 u_pick (
        .valid   (bus.rq_valid),
        .prio    (prio),
        .grant_c (pick_c)
    );

    // Ready is withheld while a response pulse is out, so accepts never run back to back.
    assign ready_c  = (state == IDLE && rs_valid == 2'b00) ? pick_c : 2'b00;
    assign accept_c = |(bus.rq_valid & ready_c);
    assign gidx_c   = ready_c[1];

    // Request fields of whichever requester is being readied.
    always_comb begin
        sel_c = '0;
        if (gidx_c) begin
            sel_c.addr = DMEM_ADDR_W'(bus.rq_addr[2*ADDR_W-1 -: ADDR_W]);
            sel_c.data = DMEM_DATA_W'(bus.rq_data[2*DATA_W-1 -: DATA_W]);
            sel_c.wen  = bus.rq_wen[1];
            sel_c.typ  = bus.rq_typ[2*MEM_TYP_W-1 -: MEM_TYP_W];
        end else begin
            sel_c.addr = DMEM_ADDR_W'(bus.rq_addr[ADDR_W-1:0]);
            sel_c.data = DMEM_DATA_W'(bus.rq_data[DATA_W-1:0]);
            sel_c.wen  = bus.rq_wen[0];
            sel_c.typ  = bus.rq_typ[MEM_TYP_W-1:0];
        end
    end

    // Transaction FSM; write_en idles high because the memory reads whenever it is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            prio             <= 1'b0;
            grant_id         <= 1'b0;
            cnt              <= '0;
            req_q            <= '0;
            busy             <= 1'b0;
            mem_req_valid    <= 1'b0;
            mem_req_write_en <= 1'b1;
            rs_valid         <= '0;
            rs_data          <= '0;
            rs_err           <= 1'b0;
        end else begin
            mem_req_valid    <= 1'b0;
            mem_req_write_en <= 1'b1;
            rs_valid         <= '0;
            rs_err           <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_q            <= sel_c;
                        grant_id         <= gidx_c;
                        mem_req_valid    <= 1'b1;
                        mem_req_write_en <= sel_c.wen;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_q.wen) begin
                        rs_valid[grant_id] <= 1'b1;
                        rs_data            <= '0;
                        prio               <= ~grant_id;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        rs_valid[grant_id] <= 1'b1;
                        rs_data            <= bus.mem_resp_data;
                        prio               <= ~grant_id;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rs_valid[grant_id] <= 1'b1;
                        rs_err             <= 1'b1;
                        rs_data            <= '0;
                        prio               <= ~grant_id;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rq_ready         = ready_c;
    assign bus.rs_valid         = rs_valid;
    assign bus.rs_data          = rs_data;
    assign bus.rs_err           = rs_err;
    assign bus.mem_req_valid    = mem_req_valid;
    assign bus.mem_req_write_en = mem_req_write_en;
    assign bus.mem_req_addr     = ADDR_W'(req_q.addr);
    assign bus.mem_req_data     = DATA_W'(req_q.data);
    assign bus.mem_req_typ      = req_q.typ;

endmodule

// File: tb/tb_sodor_dmem_arbiter.sv
// Bench for sodor_dmem_arbiter: directed scenarios then random traffic,
// scored against a transaction-level model of memory contents, latency and priority.
module tb_sodor_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic grant_id;

    sodor_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sodor_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          mem_silent = 1'b0;
    bit          spur_req   = 1'b0;
    int          mem_reads  = 0;
    bit          model_prio = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Memory model: answers a read one cycle after it is issued unless told to stay silent.
    initial begin
        logic        pend;
        logic [31:0] a;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            pend = 1'b0;
            a    = bus.mem_req_addr;
            if (!reset && bus.mem_req_write_en === 1'b0) begin
                mem_reads++;
                pend = bus.mem_req_valid && !mem_silent;
            end
            if (bus.mem_req_valid === 1'b1 && bus.mem_req_write_en === 1'b1)
                mem_arr[a] = bus.mem_req_data;
            @(posedge clk);
            #1;
            if (pend) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_arr.exists(a) ? mem_arr[a] : init_word(a);
            end else if (spur_req) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 32'hBAD0_BAD0;
                spur_req           = 1'b0;
            end else begin
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_data  = $urandom;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t);
        bus.rq_addr[r*AW +: AW] = a;
        bus.rq_data[r*DW +: DW] = d;
        bus.rq_typ[r*3 +: 3]    = t;
        bus.rq_wen[r]           = w;
        bus.rq_valid[r]         = 1'b1;
    endtask

    // Expected response from the spec's rules: write at accept+2, read at accept+3
    // with a one-cycle memory, or a timeout error after TO cycles of waiting.
    function automatic void expect_of(input bit w, input logic [31:0] a, output int lat,
                                      output bit err, output logic [31:0] d);
        if (w) begin
            lat = 2; err = 1'b0; d = '0;
        end else if (mem_silent) begin
            lat = 2 + int'(TO); err = 1'b1; d = '0;
        end else begin
            lat = 3; err = 1'b0;
            d   = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        end
    endfunction

    // Accepts requester r (already driven) and checks issue and response.
    task automatic serve(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input int exp_wait, input string tag);
        int          n;
        int          k;
        int          lat;
        bit          err;
        logic [31:0] ed;
        logic [1:0]  oh;
        oh = 2'b01 << r;
        expect_of(w, a, lat, err, ed);
        n = 0;
        #1;
        while (bus.rq_ready[r] !== 1'b1 && n < 30) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, " accept_wait"}, 64'(n), 64'(exp_wait));
        @(negedge clk);
        bus.rq_valid[r] = 1'b0;
        chk({tag, " grant_id"}, 64'(grant_id), 64'(r));
        chk({tag, " issue_busy"}, 64'(busy), 64'(1));
        chk({tag, " issue_valid_we"}, 64'({bus.mem_req_valid, bus.mem_req_write_en}), 64'({1'b1, w}));
        chk({tag, " issue_addr"}, 64'(bus.mem_req_addr), 64'(a));
        chk({tag, " issue_data"}, 64'(bus.mem_req_data), 64'(d));
        chk({tag, " issue_typ"}, 64'(bus.mem_req_typ), 64'(t));
        k = 1;
        while (bus.rs_valid === 2'b00 && k < 60) begin
            @(negedge clk); k++;
        end
        chk({tag, " latency"}, 64'(k), 64'(lat));
        chk({tag, " rs_valid"}, 64'(bus.rs_valid), 64'(oh));
        chk({tag, " rs_err"}, 64'(bus.rs_err), 64'(err));
        chk({tag, " rs_data"}, 64'(bus.rs_data), 64'(ed));
        chk({tag, " resp_busy"}, 64'(busy), 64'(0));
        if (w) ref_mem[a] = d;
        model_prio = (r == 0);
    endtask

    task automatic txn(input int r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, input string tag);
        logic [1:0] oh;
        oh = 2'b01 << r;
        drive(r, w, a, d, t);
        #1;
        chk({tag, " ready"}, 64'(bus.rq_ready), 64'(oh));
        serve(r, w, a, d, t, 0, tag);
        @(negedge clk);
        chk({tag, " pulse_end"}, 64'(bus.rs_valid), 64'(0));
    endtask

    // Both requesters at once: the model's priority bit picks the winner.
    task automatic race(input string tag);
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [2:0]  t [2];
        bit          w [2];
        int          win;
        int          lose;
        logic [1:0]  oh;
        for (int i = 0; i < 2; i++) begin
            a[i] = 32'h100 + 32'(4 * $urandom_range(0, 7));
            d[i] = $urandom;
            t[i] = 3'($urandom_range(0, 7));
            w[i] = 1'($urandom_range(0, 1));
            drive(i, w[i], a[i], d[i], t[i]);
        end
        win  = model_prio ? 1 : 0;
        lose = 1 - win;
        oh   = 2'b01 << win;
        #1;
        chk({tag, " tie_ready"}, 64'(bus.rq_ready), 64'(oh));
        serve(win, w[win], a[win], d[win], t[win], 0, {tag, " first"});
        chk({tag, " ready_in_pulse"}, 64'(bus.rq_ready), 64'(0));
        serve(lose, w[lose], a[lose], d[lose], t[lose], 1, {tag, " second"});
        @(negedge clk);
        chk({tag, " pulse_end"}, 64'(bus.rs_valid), 64'(0));
    endtask

    initial begin
        int base_reads;
        bus.rq_valid = '0;
        bus.rq_addr  = '0;
        bus.rq_data  = '0;
        bus.rq_wen   = '0;
        bus.rq_typ   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst rq_ready", 64'(bus.rq_ready), 64'(0));
        chk("rst rs_valid", 64'({bus.rs_valid, bus.rs_err}), 64'(0));
        chk("rst rs_data", 64'(bus.rs_data), 64'(0));
        chk("rst mem_valid_we", 64'({bus.mem_req_valid, bus.mem_req_write_en}), 64'(2'b01));
        chk("rst mem_addr_data", 64'({bus.mem_req_addr, bus.mem_req_data}), 64'(0));
        chk("rst typ_busy_gid", 64'({bus.mem_req_typ, busy, grant_id}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Write then read back through the other requester
        txn(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd3, "wr0");
        txn(1, 1'b0, 32'h100, 32'h0, 3'd3, "rd1");
        chk("rd1 deadbeef", 64'(bus.rs_data), 64'(32'hDEAD_BEEF));

        // Ties: r0 first, then after an r0-only transaction r1 wins the tie
        race("race_a");
        txn(0, 1'b0, 32'h104, 32'h0, 3'd2, "solo0");
        race("race_b");

        // Timeout on a silent memory
        mem_silent = 1'b1;
        txn(1, 1'b0, 32'h40, 32'h0, 3'd3, "timeout");
        mem_silent = 1'b0;

        // Spurious response in IDLE is dropped
        spur_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur rs_valid", 64'(bus.rs_valid), 64'(0));
        end
        txn(0, 1'b0, 32'h100, 32'h0, 3'd3, "after_spur");

        // Reset in the middle of WAIT
        mem_silent = 1'b1;
        drive(0, 1'b0, 32'h200, 32'h0, 3'd3);
        @(negedge clk);
        bus.rq_valid = '0;
        @(negedge clk);
        chk("rstw in_wait_busy", 64'(busy), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rstw mem_valid_we", 64'({bus.mem_req_valid, bus.mem_req_write_en}), 64'(2'b01));
        chk("rstw rs_valid", 64'(bus.rs_valid), 64'(0));
        chk("rstw busy_addr", 64'({busy, bus.mem_req_addr}), 64'(0));
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        model_prio = 1'b0;
        mem_silent = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstw no_pulse", 64'({bus.rs_valid, busy}), 64'(0));
        end
        txn(0, 1'b0, 32'h200, 32'h0, 3'd3, "post_rst");

        // Idle drive: no accesses while nobody requests
        base_reads = mem_reads;
        repeat (50) begin
            @(negedge clk);
            chk("idle drive", 64'({bus.mem_req_valid, bus.mem_req_write_en}), 64'(2'b01));
        end
        chk("idle reads", 64'(mem_reads), 64'(base_reads));

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            mem_silent = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                race("rnd_race");
            end else begin
                txn($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                    32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
                    3'($urandom_range(0, 7)), "rnd");
            end
            mem_silent = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
